// File: rtl/flash_wait_seq_pkg.sv
// Shared types and defaults for the flash wait-state sequencer.
package flash_wait_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    localparam int WAIT_CYC_DEF = 4;
    localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/flash_wait_cnt.sv
// Counts downstream-ack edges during a read.
// done_o flags the edge on which the count reaches WAIT_CYC.
module flash_wait_cnt #(
    parameter int CNT_W    = 4,
    parameter int WAIT_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (inc_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    // Combinational so the latch happens on the WAIT_CYC-th ack edge itself.
    assign done_o = inc_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/flash_wait_seq.sv
// Wishbone wait-state sequencer in front of flash_cntrl: stretches reads past
// tACC and keeps a one-word read buffer so repeated reads hit in one cycle.
module flash_wait_seq
    import flash_wait_seq_pkg::*;
#(
    parameter int WAIT_CYC = WAIT_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [15:0] wbs_dat_i,
    output logic [15:0] wbs_dat_o,
    input  logic [15:0] wbs_adr_i,
    input  logic        wbs_we_i,
    input  logic        wbs_tga_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    output logic        wbs_ack_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    output logic [15:0] wbm_adr_o,
    output logic        wbm_we_o,
    output logic        wbm_tga_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i
);

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic [15:0] rdat_q, rdat_d;
    logic [15:0] mdat_q, mdat_d;
    logic [15:0] madr_q, madr_d;
    logic        mwe_q, mwe_d;
    logic        mtga_q, mtga_d;
    logic        mact_q, mact_d;
    logic        bvld_q, bvld_d;
    logic [16:0] btag_q, btag_d;
    logic [15:0] bdat_q, bdat_d;

    logic req, hit, cnt_inc, cnt_clr, cnt_done;

    assign req = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign hit = bvld_q & (btag_q == {wbs_tga_i, wbs_adr_i});

    // Any RD edge without an ack (or with an abort) restarts the tACC count.
    assign cnt_inc = (state_q == ST_RD) & wbs_cyc_i & wbm_ack_i;
    assign cnt_clr = ~cnt_inc;

    flash_wait_cnt #(.CNT_W(CNT_W), .WAIT_CYC(WAIT_CYC)) u_cnt (
        .clk_i   (wb_clk_i),
        .rst_n_i (wb_rst_n_i),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .done_o  (cnt_done)
    );

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        rdat_d  = rdat_q;
        mdat_d  = mdat_q;
        madr_d  = madr_q;
        mwe_d   = mwe_q;
        mtga_d  = mtga_q;
        mact_d  = mact_q;
        bvld_d  = bvld_q;
        btag_d  = btag_q;
        bdat_d  = bdat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    madr_d = wbs_adr_i;
                    mtga_d = wbs_tga_i;
                    mwe_d  = wbs_we_i;
                    mdat_d = wbs_dat_i;
                    if (wbs_we_i) begin
                        mact_d  = 1'b1;
                        bvld_d  = 1'b0;
                        state_d = ST_WR;
                    end else if (hit) begin
                        ack_d  = 1'b1;
                        rdat_d = bdat_q;
                    end else begin
                        mact_d  = 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (!wbs_cyc_i) begin
                    mact_d  = 1'b0;
                    mwe_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_done) begin
                    rdat_d  = wbm_dat_i;
                    bvld_d  = 1'b1;
                    btag_d  = {mtga_q, madr_q};
                    bdat_d  = wbm_dat_i;
                    ack_d   = 1'b1;
                    mact_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (!wbs_cyc_i || wbm_ack_i) begin
                    ack_d   = wbs_cyc_i;
                    mact_d  = 1'b0;
                    mwe_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
            mdat_q  <= '0;
            madr_q  <= '0;
            mwe_q   <= 1'b0;
            mtga_q  <= 1'b0;
            mact_q  <= 1'b0;
            bvld_q  <= 1'b0;
            btag_q  <= '0;
            bdat_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
            mdat_q  <= mdat_d;
            madr_q  <= madr_d;
            mwe_q   <= mwe_d;
            mtga_q  <= mtga_d;
            mact_q  <= mact_d;
            bvld_q  <= bvld_d;
            btag_q  <= btag_d;
            bdat_q  <= bdat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign wbm_dat_o = mdat_q;
    assign wbm_adr_o = madr_q;
    assign wbm_we_o  = mwe_q;
    assign wbm_tga_o = mtga_q;
    assign wbm_stb_o = mact_q;
    assign wbm_cyc_o = mact_q;

endmodule

// File: tb/tb_flash_wait_seq.sv
// Directed bench for flash_wait_seq: transaction-level buffer model plus a
// flash_cntrl stand-in whose pad data is garbage until tACC has elapsed.
module tb_flash_wait_seq;

    localparam int WC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_dat_i, s_dat_o, s_adr, m_dat_o, m_dat_i, m_adr;
    logic        s_we, s_tga, s_stb, s_cyc, s_ack;
    logic        m_we, m_tga, m_stb, m_cyc, m_ack;

    always #5 clk = ~clk;

    flash_wait_seq #(.WAIT_CYC(WC), .CNT_W(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_dat_i  (s_dat_i),
        .wbs_dat_o  (s_dat_o),
        .wbs_adr_i  (s_adr),
        .wbs_we_i   (s_we),
        .wbs_tga_i  (s_tga),
        .wbs_stb_i  (s_stb),
        .wbs_cyc_i  (s_cyc),
        .wbs_ack_o  (s_ack),
        .wbm_dat_o  (m_dat_o),
        .wbm_dat_i  (m_dat_i),
        .wbm_adr_o  (m_adr),
        .wbm_we_o   (m_we),
        .wbm_tga_o  (m_tga),
        .wbm_stb_o  (m_stb),
        .wbm_cyc_o  (m_cyc),
        .wbm_ack_i  (m_ack)
    );

    function automatic logic [15:0] mem(input logic [15:0] a);
        return (a == 16'h0123) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    // flash_cntrl stand-in: acks while strobed; data settles after WC-1 ack edges.
    logic [3:0] ack_age;
    assign m_ack   = m_stb & m_cyc;
    assign m_dat_i = (ack_age >= 4'(WC - 1)) ? mem(m_adr) : 16'hDEAD;
    always @(posedge clk or negedge rst_n)
        if (!rst_n)     ack_age <= '0;
        else if (m_ack) ack_age <= ack_age + {3'b0, ack_age != 4'hF};
        else            ack_age <= '0;

    int ds_cnt = 0, acnt = 0;
    always @(posedge m_stb) ds_cnt = ds_cnt + 1;
    always @(posedge clk) if (s_ack === 1'b1) acnt = acnt + 1;

    int n_chk = 0, n_err = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one-entry buffer plus per-cycle expected outputs.
    logic        mv;
    logic [16:0] mtag;
    logic [15:0] mdat;
    logic        chk_en, exp_ack, exp_stb, exp_we;
    logic [15:0] exp_dat, exp_adr, exp_wdat;

    always @(negedge clk) if (chk_en) begin
        chk("ack", s_ack, exp_ack);
        chk("rdata", s_dat_o, exp_dat);
        chk("stb", m_stb, exp_stb);
        chk("cyc", m_cyc, exp_stb);
        if (exp_stb) begin
            chk("m_we", m_we, exp_we);
            chk("m_adr", m_adr, exp_adr);
            if (exp_we) chk("m_wdat", m_dat_o, exp_wdat);
        end
    end

    // Hit = 1 edge, write = 2 edges, miss = WC+1 edges from presentation to ack.
    task automatic req(input logic we, input logic tga, input logic [15:0] adr,
                       input logic [15:0] dat, output int got);
        int L;
        logic hitm;
        logic [15:0] nd;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_tga = tga; s_adr = adr; s_dat_i = dat;
        hitm = !we && mv && (mtag == {tga, adr});
        nd = exp_dat;
        if (we) begin
            L = 2; mv = 1'b0;
        end else if (hitm) begin
            L = 1; nd = mdat;
        end else begin
            L = WC + 1; nd = mem(adr); mv = 1'b1; mtag = {tga, adr}; mdat = nd;
        end
        got = 0;
        for (int k = 1; k <= L; k++) begin
            @(posedge clk); #1;
            exp_stb = !hitm && (k < L);
            exp_we = we; exp_adr = adr; exp_wdat = dat;
            exp_ack = (k == L);
            if (k == L) exp_dat = nd;
            if (s_ack && got == 0) got = k;
        end
    endtask

    task automatic drop();
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        exp_ack = 1'b0; exp_stb = 1'b0;
    endtask

    task automatic abort_rd(input logic [15:0] adr, input int n);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_tga = 1'b0; s_adr = adr;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            exp_stb = 1'b1; exp_we = 1'b0; exp_adr = adr; exp_ack = 1'b0;
        end
        drop();
        tick();
    endtask

    int got, d0, a0;

    initial begin
        chk_en = 0; mv = 0; mtag = '0; mdat = '0;
        exp_ack = 0; exp_stb = 0; exp_we = 0; exp_dat = '0; exp_adr = '0; exp_wdat = '0;
        s_dat_i = '0; s_adr = '0; s_we = 0; s_tga = 0; s_stb = 0; s_cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", s_ack, 1'b0);
        chk("rst_rdat", s_dat_o, 16'h0);
        chk("rst_stb", m_stb, 1'b0);
        chk("rst_cyc", m_cyc, 1'b0);
        chk("rst_we", m_we, 1'b0);
        chk("rst_madr", m_adr, 16'h0);
        chk("rst_mdat", m_dat_o, 16'h0);
        @(negedge clk); rst_n = 1'b1; #1; chk_en = 1;

        // Cold miss, then hit on the same word.
        d0 = ds_cnt;
        req(0, 0, 16'h0123, 16'h0, got);
        chk("miss_lat", got, 5);
        chk("miss_dat", s_dat_o, 16'hBEEF);
        chk("miss_ds", ds_cnt - d0, 1);
        drop(); tick();
        d0 = ds_cnt;
        req(0, 0, 16'h0123, 16'h0, got);
        chk("hit_lat", got, 1);
        chk("hit_dat", s_dat_o, 16'hBEEF);
        chk("hit_ds", ds_cnt - d0, 0);
        drop(); tick();

        // Base write invalidates the buffer; tga=0 write still acks.
        req(1, 1, 16'h0040, 16'h0ABC, got);
        chk("wr_lat", got, 2);
        chk("wr_rdat", s_dat_o, 16'hBEEF);
        drop(); tick();
        req(0, 0, 16'h0123, 16'h0, got);
        chk("inval_lat", got, 5);
        drop(); tick();
        req(1, 0, 16'h0200, 16'h1234, got);
        chk("wr0_lat", got, 2);
        drop(); tick();

        // Aborts: no ack, buffer untouched, counter restarts.
        a0 = acnt; d0 = ds_cnt;
        abort_rd(16'h0077, 2);
        abort_rd(16'h0077, 4);
        chk("abort_acks", acnt - a0, 0);
        chk("abort_ds", ds_cnt - d0, 2);
        req(0, 0, 16'h0077, 16'h0, got);
        chk("post_abort_lat", got, 5);
        chk("post_abort_dat", s_dat_o, 16'h5A2D);
        drop(); tick();

        // Back-to-back reads with strobe held.
        a0 = acnt;
        req(0, 0, 16'h0010, 16'h0, got);
        chk("b2b1_lat", got, 5);
        s_adr = 16'h0011;
        tick();
        req(0, 0, 16'h0011, 16'h0, got);
        chk("b2b2_lat", got, 5);
        chk("b2b2_dat", s_dat_o, 16'h5A4B);
        tick();
        req(0, 0, 16'h0011, 16'h0, got);
        chk("b2b_hit_lat", got, 1);
        drop(); tick();
        chk("b2b_acks", acnt - a0, 3);

        // Reset mid-RD.
        req(0, 0, 16'h0300, 16'h0, got);
        drop(); tick();
        s_cyc = 1; s_stb = 1; s_we = 0; s_tga = 0; s_adr = 16'h0123;
        repeat (2) begin
            @(posedge clk); #1;
            exp_stb = 1; exp_we = 0; exp_adr = 16'h0123; exp_ack = 0;
        end
        #2; chk_en = 0; rst_n = 1'b0; #1;
        chk("arst_ack", s_ack, 1'b0);
        chk("arst_stb", m_stb, 1'b0);
        chk("arst_rdat", s_dat_o, 16'h0);
        drop();
        mv = 0; exp_dat = '0; exp_ack = 0; exp_stb = 0;
        @(negedge clk); rst_n = 1'b1; #1; chk_en = 1;
        req(0, 0, 16'h0300, 16'h0, got);
        chk("arst_buf_lat", got, 5);
        drop(); tick();
        req(0, 0, 16'h0123, 16'h0, got);
        chk("arst_miss_lat", got, 5);
        chk("arst_miss_dat", s_dat_o, 16'hBEEF);
        drop(); tick();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
